spi_master_gen: RTL

Parametrised, full-duplex SPI master. It is the successor to the fixed 12-bit, mode-0, single-slave master. It adds:
- configurable word width and clock divider
- all four CPOL/CPHA modes, selectable per transfer
- LSB/MSB-first ordering
- MISO capture
- multiple one-hot chip selects
- a ready/start handshake with a done pulse

All logic runs on one system clock. SCLK is a registered output, never used as a clock. Sits between the control FSM and the SPI pins.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_clk_div.sv | 52 +++++
 rtl/spi_master_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the generic SPI master.
//                state_t    - transfer sequencer states
//                spi_mode_t - per-transfer mode latched on accept
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    // Smallest divider that still leaves a distinct count for the tick.
    localparam int MIN_CLK_DIV = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ============================================================================
//  Module      : spi_clk_div
//  Description : Half-period divider for the SPI master. Counts 0..CLK_DIV-1
//                while enabled and flags a one-cycle tick on the last count.
//  Ports       : clk    - system clock
//                rst    - asynchronous active-low reset
//                i_en   - count enable (transfer in progress)
//                i_clr  - synchronous clear (transfer accepted)
//                o_tick - high during the last count of each half-period
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                 c_CNT_W    = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < MIN_CLK_DIV) begin : g_bad_clk_div
            $error("spi_clk_div: CLK_DIV must be at least 2");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_cnt;

    // Combinational so the sequencer acts on the same edge the count wraps.
    assign o_tick = i_en && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master_gen.sv
// ============================================================================
//  Module      : spi_master_gen
//  Description : Parametrised full-duplex SPI master. Supports all four
//                CPOL/CPHA modes, LSB/MSB-first ordering and one-hot chip
//                selects. SCLK is a registered data output, never a clock.
//  Ports       : clk       - system clock (rising edge)
//                rst       - asynchronous active-low reset
//                start     - transfer request, accepted when start && ready
//                ready     - idle and able to accept
//                din       - transmit word (sampled on accept)
//                cs_sel    - target slave index (sampled on accept)
//                cpol      - SCLK idle level (sampled on accept)
//                cpha      - 0: sample leading edge, 1: sample trailing edge
//                lsb_first - 1: bit 0 first, 0: bit DATA_W-1 first
//                sclk      - SPI clock
//                cs_n      - active-low chip selects, at most one low
//                mosi      - serial data out
//                miso      - serial data in
//                dout      - last received word, held until next done
//                done      - one-cycle pulse at end of transfer
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_gen
    import spi_pkg::*;
#(
    parameter  int DATA_W  = 12,
    parameter  int CLK_DIV = 10,
    parameter  int NUM_CS  = 4,
    localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] dout,
    output logic              done
);

    localparam int                  c_EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(2 * DATA_W);

    generate
        if (DATA_W < 2) begin : g_bad_data_w
            $error("spi_master_gen: DATA_W must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    spi_mode_t           r_mode;
    logic                r_ready;
    logic                r_sclk;
    logic [NUM_CS-1:0]   r_cs_n;
    logic                r_mosi;
    logic [DATA_W-1:0]   r_dout;
    logic                r_done;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [c_EDGE_W-1:0] r_edge;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                w_accept;
    logic                w_tick;
    logic [c_EDGE_W-1:0] w_edge_next;
    logic                w_sample;
    logic                w_shift;
    logic [DATA_W-1:0]   w_rx_next;
    logic [NUM_CS-1:0]   w_cs_dec;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    assign w_accept    = (r_state == IDLE) && r_ready && start;
    assign w_edge_next = r_edge + 1'b1;

    // Odd edge numbers are leading edges. In mode CPHA=0 the final trailing
    // edge must not shift, otherwise the last bit would be cut short.
    assign w_sample = r_mode.cpha ? !w_edge_next[0] : w_edge_next[0];
    assign w_shift  = r_mode.cpha ? w_edge_next[0]
                                  : (!w_edge_next[0] && (w_edge_next != c_EDGE_LAST));

    // Receive register fills in the same order the word is transmitted.
    assign w_rx_next = r_mode.lsb_first ? {miso, r_rx[DATA_W-1:1]}
                                        : {r_rx[DATA_W-2:0], miso};

    // Out-of-range selects decode to no active line.
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state != IDLE),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------------
    // Transfer sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_mode  <= '0;
            r_ready <= 1'b1;
            r_sclk  <= 1'b0;
            r_cs_n  <= '1;
            r_mosi  <= 1'b0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_edge  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= cpol;
                    r_mosi <= 1'b0;
                    if (w_accept) begin
                        r_ready          <= 1'b0;
                        r_mode.cpol      <= cpol;
                        r_mode.cpha      <= cpha;
                        r_mode.lsb_first <= lsb_first;
                        r_cs_n           <= w_cs_dec;
                        r_rx             <= '0;
                        r_edge           <= '0;
                        r_state          <= LEAD;
                        if (!cpha) begin
                            // CPHA=0 presents the first bit before the first edge.
                            r_mosi <= first_bit(din, lsb_first);
                            r_tx   <= shift_out(din, lsb_first);
                        end else begin
                            r_tx   <= din;
                        end
                    end else begin
                        // Also covers the done cycle: ready returns one cycle later.
                        r_ready <= 1'b1;
                    end
                end

                LEAD: begin
                    if (w_tick) begin
                        r_edge  <= '0;
                        r_state <= XFER;
                    end
                end

                XFER: begin
                    if (w_tick) begin
                        r_edge <= w_edge_next;
                        if (w_edge_next == c_EDGE_LAST) begin
                            r_sclk  <= r_mode.cpol;
                            r_state <= TRAIL;
                        end else begin
                            r_sclk  <= ~r_sclk;
                        end
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_shift) begin
                            r_mosi <= first_bit(r_tx, r_mode.lsb_first);
                            r_tx   <= shift_out(r_tx, r_mode.lsb_first);
                        end
                    end
                end

                TRAIL: begin
                    if (w_tick) begin
                        r_cs_n  <= '1;
                        r_mosi  <= 1'b0;
                        r_dout  <= r_rx;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign sclk  = r_sclk;
    assign cs_n  = r_cs_n;
    assign mosi  = r_mosi;
    assign dout  = r_dout;
    assign done  = r_done;

endmodule

`default_nettype wire
